// File: rtl/btn_cmd_arbiter.sv
// Push-button front end. It synchronises and debounces four buttons, detects press
// edges, arbitrates by fixed priority, and holds one pending command for the CPU port.
module btn_cmd_arbiter #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_W           = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  btn_raw,
   input  logic        rd_strobe,
   input  logic        clr_overrun,
   output logic        cmd_valid,
   output logic [2:0]  cmd_code,
   output logic        overrun,
   output logic [15:0] port_word
);

   localparam int unsigned N_BTN = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [2:0] CODE_NONE = 3'd0;
   localparam logic [2:0] CODE_ADD  = 3'd1;
   localparam logic [2:0] CODE_SUB  = 3'd2;
   localparam logic [2:0] CODE_MUL  = 3'd3;
   localparam logic [2:0] CODE_EQ   = 3'd4;

   // Bit order follows btn_raw: [3]=add, [2]=sub, [1]=mul, [0]=equals
   logic [N_BTN-1:0] sync1, sync2, stable, stable_d;
   logic [CNT_W-1:0] cnt [N_BTN];

   logic [N_BTN-1:0] press;
   logic             press_any;
   logic             press_multi;
   logic [2:0]       win_code;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1    <= '0;
         sync2    <= '0;
         stable_d <= '0;
      end else begin
         sync1    <= btn_raw;
         sync2    <= sync1;
         stable_d <= stable;
      end
   end

   // A level change is accepted after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable <= '0;
         for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Equals wins over add, add over sub, and sub over mul
   always_comb begin
      press       = stable & ~stable_d;
      press_any   = |press;
      press_multi = |(press & (press - 4'(1)));
      win_code    = CODE_NONE;
      if (press[0])      win_code = CODE_EQ;
      else if (press[3]) win_code = CODE_ADD;
      else if (press[2]) win_code = CODE_SUB;
      else if (press[1]) win_code = CODE_MUL;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_valid <= 1'b0;
         cmd_code  <= CODE_NONE;
      end else if (press_any && (!cmd_valid || rd_strobe)) begin
         cmd_valid <= 1'b1;
         cmd_code  <= win_code;
      end else if (rd_strobe && !press_any) begin
         cmd_valid <= 1'b0;
         cmd_code  <= CODE_NONE;
      end
   end

   // A dropped press takes priority over a same-cycle clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overrun <= 1'b0;
      end else if (press_multi || (press_any && cmd_valid && !rd_strobe)) begin
         overrun <= 1'b1;
      end else if (clr_overrun) begin
         overrun <= 1'b0;
      end
   end

   assign port_word = {cmd_valid, overrun, 11'b0, cmd_code};

endmodule
